gemm_mac_engine: RTL

Parametrised successor of the fixed-size GEMM accelerator. Computes C = A*B, or C += A*B in accumulate mode, over runtime M/K/N. A, B and C are row-major with programmable base addresses and signed/unsigned operand mode. One MAC per cycle against the three single-port memories (1-cycle registered read). Sits between the control/config logic and the A/B/C memories.

---
 rtl/gemm_pkg.sv | 21 ++
 rtl/gemm_mac_unit.sv | 73 +++++++
 rtl/gemm_mac_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared types for the GEMM MAC engine.
// State encoding, dimension type and operand-extension width.
package gemm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE,
    ERR
  } state_e;

  typedef logic [15:0] dim_t;

  function automatic int ext_width(int w);
    return w + 1;
  endfunction

  localparam int ExtWidth = ext_width(8);

endpackage

// File: rtl/gemm_mac_unit.sv
// Operand extension, multiply, accumulate and final C add.
// GEMM_SAT_EN widens the accumulator and saturates the written value.
module gemm_mac_unit
  import gemm_pkg::*;
#(
  parameter int InW  = 8,
  parameter int OutW = 32,
  parameter int AccW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            acc_en_i,
  input  logic            signed_i,
  input  logic            accum_i,
  input  logic [InW-1:0]  a_i,
  input  logic [InW-1:0]  b_i,
  input  logic [OutW-1:0] c_i,
  output logic [OutW-1:0] result_o
);

  localparam int ExtW = ext_width(InW);

  logic signed [ExtW-1:0]   a_x;
  logic signed [ExtW-1:0]   b_x;
  logic signed [2*ExtW-1:0] prod;
  logic signed [AccW-1:0]   prod_x;
  logic signed [AccW-1:0]   c_x;
  logic signed [AccW-1:0]   acc_q;
  logic signed [AccW-1:0]   sum;

  assign a_x    = {signed_i & a_i[InW-1], a_i};
  assign b_x    = {signed_i & b_i[InW-1], b_i};
  assign prod   = a_x * b_x;
  assign prod_x = AccW'(prod);
  assign c_x    = signed_i ? AccW'($signed(c_i))
                           : AccW'(c_i);
  assign sum    = acc_q + prod_x
                + (accum_i ? c_x : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (acc_en_i) begin
      acc_q <= acc_q + prod_x;
    end
  end

`ifdef GEMM_SAT_EN
  localparam logic signed [AccW-1:0] SMax =
    $signed({{(AccW-OutW+1){1'b0}}, {(OutW-1){1'b1}}});
  localparam logic signed [AccW-1:0] SMin =
    $signed({{(AccW-OutW+1){1'b1}}, {(OutW-1){1'b0}}});
  localparam logic signed [AccW-1:0] UMax =
    $signed({{(AccW-OutW){1'b0}}, {OutW{1'b1}}});

  always_comb begin
    result_o = sum[OutW-1:0];
    if (signed_i) begin
      if (sum > SMax) result_o = SMax[OutW-1:0];
      else if (sum < SMin) result_o = SMin[OutW-1:0];
    end else begin
      if (sum < 0) result_o = '0;
      else if (sum > UMax) result_o = '1;
    end
  end
`else
  assign result_o = sum[OutW-1:0];
`endif

endmodule

// File: rtl/gemm_mac_engine.sv
// Runtime-sized GEMM engine, one MAC per cycle, m/n/k loop order.
// Optional saturation via GEMM_SAT_EN.
module gemm_mac_engine
  import gemm_pkg::*;
#(
  parameter int AddrWidth    = 12,
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int DimWidth     = $bits(dim_t)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DimWidth-1:0]     M_rows_i,
  input  logic [DimWidth-1:0]     K_cols_i,
  input  logic [DimWidth-1:0]     N_cols_i,
  input  logic [AddrWidth-1:0]    base_addr_A_i,
  input  logic [AddrWidth-1:0]    base_addr_B_i,
  input  logic [AddrWidth-1:0]    base_addr_C_i,
  input  logic                    signed_mode_i,
  input  logic                    accumulate_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [AddrWidth-1:0]    A_addr_o,
  input  logic [InDataWidth-1:0]  A_rd_data_i,
  output logic [AddrWidth-1:0]    B_addr_o,
  input  logic [InDataWidth-1:0]  B_rd_data_i,
  output logic [AddrWidth-1:0]    C_addr_o,
  output logic                    C_we_o,
  output logic [OutDataWidth-1:0] C_wr_data_o,
  input  logic [OutDataWidth-1:0] C_rd_data_i
);

`ifdef GEMM_SAT_EN
  localparam int AccWidth = OutDataWidth + DimWidth;
`else
  localparam int AccWidth = OutDataWidth;
`endif

  typedef logic [DimWidth-1:0]  cnt_t;
  typedef logic [AddrWidth-1:0] addr_t;

  state_e state;
  cnt_t   m_dim, k_dim, n_dim;
  cnt_t   m_q, n_q, k_q;
  addr_t  a_row, b_col, b_base;
  logic   sgn_q, acc_mode_q;
  logic   zero_dim, k_last, n_last, m_last;
  logic   mac_clr, mac_en;
  logic [OutDataWidth-1:0] mac_res;

  assign zero_dim = (M_rows_i == '0)
                  | (K_cols_i == '0)
                  | (N_cols_i == '0);
  assign k_last = k_q == k_dim - cnt_t'(1);
  assign n_last = n_q == n_dim - cnt_t'(1);
  assign m_last = m_q == m_dim - cnt_t'(1);

  // First FETCH cycle sees stale read data, so it is not accumulated.
  assign mac_en  = (state == FETCH) && (k_q != '0);
  assign mac_clr = (state == WRITE);

  assign C_wr_data_o = C_we_o ? mac_res : '0;

  gemm_mac_unit #(
    .InW  (InDataWidth),
    .OutW (OutDataWidth),
    .AccW (AccWidth)
  ) u_mac (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (mac_clr),
    .acc_en_i (mac_en),
    .signed_i (sgn_q),
    .accum_i  (acc_mode_q),
    .a_i      (A_rd_data_i),
    .b_i      (B_rd_data_i),
    .c_i      (C_rd_data_i),
    .result_o (mac_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      m_dim      <= '0;
      k_dim      <= '0;
      n_dim      <= '0;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      a_row      <= '0;
      b_col      <= '0;
      b_base     <= '0;
      sgn_q      <= 1'b0;
      acc_mode_q <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      C_we_o     <= 1'b0;
      A_addr_o   <= '0;
      B_addr_o   <= '0;
      C_addr_o   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      C_we_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            m_dim      <= M_rows_i;
            k_dim      <= K_cols_i;
            n_dim      <= N_cols_i;
            sgn_q      <= signed_mode_i;
            acc_mode_q <= accumulate_i;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            if (zero_dim) begin
              state  <= ERR;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state    <= FETCH;
              busy_o   <= 1'b1;
              a_row    <= base_addr_A_i;
              b_col    <= base_addr_B_i;
              b_base   <= base_addr_B_i;
              A_addr_o <= base_addr_A_i;
              B_addr_o <= base_addr_B_i;
              C_addr_o <= base_addr_C_i;
            end
          end
        end
        FETCH: begin
          if (k_last) begin
            state  <= WRITE;
            C_we_o <= 1'b1;
          end else begin
            k_q      <= k_q + cnt_t'(1);
            A_addr_o <= A_addr_o + addr_t'(1);
            B_addr_o <= B_addr_o + addr_t'(n_dim);
          end
        end
        WRITE: begin
          k_q <= '0;
          if (n_last && m_last) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (n_last) begin
            state    <= FETCH;
            n_q      <= '0;
            m_q      <= m_q + cnt_t'(1);
            a_row    <= a_row + addr_t'(k_dim);
            A_addr_o <= a_row + addr_t'(k_dim);
            b_col    <= b_base;
            B_addr_o <= b_base;
            C_addr_o <= C_addr_o + addr_t'(1);
          end else begin
            state    <= FETCH;
            n_q      <= n_q + cnt_t'(1);
            A_addr_o <= a_row;
            b_col    <= b_col + addr_t'(1);
            B_addr_o <= b_col + addr_t'(1);
            C_addr_o <= C_addr_o + addr_t'(1);
          end
        end
        DONE: state <= IDLE;
        ERR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
